pmp_csr_ctrl: RTL and testbench

PMP_CSR_CTRL -- requirements
Module: pmp_csr_ctrl

---
 rtl/pmp_csr_ctrl_pkg.sv | 42 ++++
 rtl/pmp_csr_ctrl_if.sv | 15 +
 rtl/pmp_csr_ctrl_decode.sv | 60 ++++++
 rtl/pmp_csr_ctrl.sv | 179 +++++++++++++++++
 tb/tb_pmp_csr_ctrl.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/pmp_csr_ctrl_pkg.sv
// Shared PMP types: A-field encoding, cfg byte bit positions and the
// controller state enum, plus the cfg byte legalisation helper.
// Optional feature macro: PMP_NA4_EN (keeps A=NA4; otherwise NA4 is stored as OFF).
package lstypes;

    typedef enum logic [1:0] {
        A_OFF   = 2'b00,
        A_TOR   = 2'b01,
        A_NA4   = 2'b10,
        A_NAPOT = 2'b11
    } pmp_a_e;

    typedef enum logic {
        IDLE   = 1'b0,
        DECODE = 1'b1
    } ctrl_state_e;

    localparam int CFG_R    = 0;
    localparam int CFG_W    = 1;
    localparam int CFG_X    = 2;
    localparam int CFG_A_LO = 3;
    localparam int CFG_A_HI = 4;
    localparam int CFG_L    = 7;

    // Turn a written cfg byte into the value actually stored: reserved bits
    // 6:5 read zero, W-without-R collapses to no access, and NA4 becomes OFF
    // when the granule is 8 bytes.
    function automatic logic [7:0] cfg_legalize(input logic [7:0] d);
        logic [7:0] r;
        r = d & 8'h9F;
        if (r[CFG_W] && !r[CFG_R]) begin
            r[CFG_W] = 1'b0;
        end
`ifndef PMP_NA4_EN
        if (r[CFG_A_HI:CFG_A_LO] == A_NA4) begin
            r[CFG_A_HI:CFG_A_LO] = A_OFF;
        end
`endif
        return r;
    endfunction

endpackage

// File: rtl/pmp_csr_ctrl_if.sv
// Decoded PMP region bundle: one valid/locked/prot/start/aend set per entry.
// start/aend are address bits [NPHYS-1:2] (word granules).
interface pmp_csr_ctrl_if #(
    parameter int NPHYS   = 56,
    parameter int NUM_PMP = 5
);
    logic [NUM_PMP-1:0]                  valid;
    logic [NUM_PMP-1:0]                  locked;
    logic [NUM_PMP-1:0][2:0]             prot;
    logic [NUM_PMP-1:0][NPHYS-1:2]       start;
    logic [NUM_PMP-1:0][NPHYS-1:2]       aend;

    modport master (output valid, locked, prot, start, aend);
    modport slave  (input  valid, locked, prot, start, aend);
endinterface

// File: rtl/pmp_csr_ctrl_decode.sv
// Combinational range decode of a single PMP entry; the controller
// time-shares one instance across all entries.
// Optional feature macro: PMP_NA4_EN (adds the NA4 decode arm).
module pmp_decode
    import lstypes::*;
#(
    parameter int NPHYS = 56
) (
    input  logic [7:0]       i_cfg,
    input  logic [NPHYS-3:0] i_addr,
    input  logic [NPHYS-3:0] i_prev_addr,
    input  logic             i_first,
    output logic             o_valid,
    output logic             o_locked,
    output logic [2:0]       o_prot,
    output logic [NPHYS-3:0] o_start,
    output logic [NPHYS-3:0] o_aend
);
    localparam logic [NPHYS-3:0] LP_ONE = {{(NPHYS-3){1'b0}}, 1'b1};

    logic [NPHYS-3:0] w_tor_base;
    logic [NPHYS-3:0] w_napot_mask;

    // Entry 0 in TOR mode starts at address zero.
    assign w_tor_base   = i_first ? '0 : i_prev_addr;
    // Ones in bit positions 0..k where k is the trailing-ones count; all-ones
    // input gives an all-ones mask, i.e. the full address range.
    assign w_napot_mask = i_addr ^ (i_addr + LP_ONE);

    // Map the A field to a [start, aend] range.
    always_comb begin
        o_valid  = 1'b0;
        o_start  = '0;
        o_aend   = '0;
        o_locked = i_cfg[CFG_L];
        o_prot   = i_cfg[CFG_X:CFG_R];
        case (pmp_a_e'(i_cfg[CFG_A_HI:CFG_A_LO]))
            A_TOR: begin
                o_start = w_tor_base;
                o_aend  = i_addr - LP_ONE;
                o_valid = (i_addr > w_tor_base);
            end
`ifdef PMP_NA4_EN
            A_NA4: begin
                o_start = i_addr;
                o_aend  = i_addr;
                o_valid = 1'b1;
            end
`endif
            A_NAPOT: begin
                o_start = i_addr & ~w_napot_mask;
                o_aend  = i_addr | w_napot_mask;
                o_valid = 1'b1;
            end
            default: begin
                o_valid = 1'b0;
            end
        endcase
    end
endmodule

// File: rtl/pmp_csr_ctrl.sv
// PMP CSR controller: holds pmpcfg0/pmpaddr registers, applies lock and
// legalisation rules, and rebuilds the decoded ranges one entry per cycle.
// Optional feature macro: PMP_NA4_EN (see lstypes::cfg_legalize / pmp_decode).
//
// Write handshake: a write transfers on a rising edge where csr_wr_valid and
// csr_wr_ready are both high. ready is high only in IDLE and never depends
// on valid; a requester holds valid and its payload steady until it sees
// the transfer edge.
module pmp_csr_ctrl
    import lstypes::*;
#(
    parameter int NPHYS   = 56,
    parameter int NUM_PMP = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  csr_wr_valid,
    output logic                  csr_wr_ready,
    input  logic                  csr_wr_sel,
    input  logic [2:0]            csr_wr_index,
    input  logic [63:0]           csr_wr_data,
    input  logic                  csr_rd_sel,
    input  logic [2:0]            csr_rd_index,
    output logic [63:0]           csr_rd_data,
    output logic                  busy,
    output ctrl_state_e           o_dbg_state,
    pmp_csr_ctrl_if.master        pmp
);
    logic [NUM_PMP-1:0][7:0]       r_cfg;
    logic [NUM_PMP-1:0][NPHYS-3:0] r_addr;
    ctrl_state_e                   r_state;
    ctrl_state_e                   w_next_state;
    logic [2:0]                    r_idx;
    logic [2:0]                    r_last;

    logic [NUM_PMP-1:0]            r_valid;
    logic [NUM_PMP-1:0]            r_locked;
    logic [NUM_PMP-1:0][2:0]       r_prot;
    logic [NUM_PMP-1:0][NPHYS-3:0] r_start;
    logic [NUM_PMP-1:0][NPHYS-3:0] r_aend;

    logic                          w_accept;
    logic                          w_start;
    logic                          w_idx_ok;
    logic                          w_nxt_ok;
    logic [2:0]                    w_nxt_idx;
    logic                          w_addr_lock;
    logic                          w_dec_valid;
    logic                          w_dec_locked;
    logic [2:0]                    w_dec_prot;
    logic [NPHYS-3:0]              w_dec_start;
    logic [NPHYS-3:0]              w_dec_aend;

    assign w_accept  = csr_wr_valid && (r_state == IDLE);
    assign w_idx_ok  = 32'(csr_wr_index) < 32'(NUM_PMP);
    assign w_nxt_idx = csr_wr_index + 3'd1;
    assign w_nxt_ok  = (32'(csr_wr_index) + 32'd1) < 32'(NUM_PMP);
    // An address is frozen by its own lock, or by a locked TOR entry above it
    // that uses this address as its base.
    assign w_addr_lock = r_cfg[csr_wr_index][CFG_L] ||
                         (w_nxt_ok && r_cfg[w_nxt_idx][CFG_L] &&
                          (r_cfg[w_nxt_idx][CFG_A_HI:CFG_A_LO] == A_TOR));
    // Out-of-range pmpaddr writes are accepted but change nothing.
    assign w_start   = w_accept && (!csr_wr_sel || w_idx_ok);

    // Raw CSR storage, updated on the accepting edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cfg  <= '0;
            r_addr <= '0;
        end else if (w_accept) begin
            if (!csr_wr_sel) begin
                for (int b = 0; b < NUM_PMP; b++) begin
                    if (!r_cfg[b][CFG_L]) begin
                        r_cfg[b] <= cfg_legalize(csr_wr_data[8*b +: 8]);
                    end
                end
            end else if (w_idx_ok && !w_addr_lock) begin
                r_addr[csr_wr_index] <= csr_wr_data[NPHYS-3:0];
            end
        end
    end

    // Controller state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, ready and busy.
    always_comb begin
        w_next_state = r_state;
        csr_wr_ready = 1'b0;
        busy         = 1'b0;
        case (r_state)
            IDLE: begin
                csr_wr_ready = 1'b1;
                if (w_start) begin
                    w_next_state = DECODE;
                end
            end
            DECODE: begin
                busy = 1'b1;
                if (r_idx == r_last) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign o_dbg_state = r_state;

    // Decode schedule: first entry and last entry of the rebuild.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx  <= 3'd0;
            r_last <= 3'd0;
        end else if (r_state == IDLE) begin
            if (w_start) begin
                r_idx  <= csr_wr_sel ? csr_wr_index : 3'd0;
                r_last <= !csr_wr_sel ? 3'(NUM_PMP - 1)
                                      : (w_nxt_ok ? w_nxt_idx : csr_wr_index);
            end
        end else begin
            r_idx <= r_idx + 3'd1;
        end
    end

    pmp_decode #(.NPHYS(NPHYS)) u_decode (
        .i_cfg       (r_cfg[r_idx]),
        .i_addr      (r_addr[r_idx]),
        .i_prev_addr (r_addr[r_idx - 3'd1]),
        .i_first     (r_idx == 3'd0),
        .o_valid     (w_dec_valid),
        .o_locked    (w_dec_locked),
        .o_prot      (w_dec_prot),
        .o_start     (w_dec_start),
        .o_aend      (w_dec_aend)
    );

    // Decoded outputs: each entry changes only in its own decode cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid  <= '0;
            r_locked <= '0;
            r_prot   <= '0;
            r_start  <= '0;
            r_aend   <= '0;
        end else if (r_state == DECODE) begin
            r_valid[r_idx]  <= w_dec_valid;
            r_locked[r_idx] <= w_dec_locked;
            r_prot[r_idx]   <= w_dec_prot;
            r_start[r_idx]  <= w_dec_start;
            r_aend[r_idx]   <= w_dec_aend;
        end
    end

    assign pmp.valid  = r_valid;
    assign pmp.locked = r_locked;
    assign pmp.prot   = r_prot;
    assign pmp.start  = r_start;
    assign pmp.aend   = r_aend;

    // Combinational readback; unimplemented cfg bytes and addresses read 0.
    always_comb begin
        csr_rd_data = '0;
        if (!csr_rd_sel) begin
            for (int b = 0; b < NUM_PMP; b++) begin
                csr_rd_data[8*b +: 8] = r_cfg[b];
            end
        end else if (32'(csr_rd_index) < 32'(NUM_PMP)) begin
            csr_rd_data[NPHYS-3:0] = r_addr[csr_rd_index];
        end
    end
endmodule

// File: tb/tb_pmp_csr_ctrl.sv
// Directed bench for pmp_csr_ctrl: a vector table of write -> decoded entry
// and readback expectations, plus sequences for back-to-back holding and
// reset in the middle of a decode.
module tb_pmp_csr_ctrl;
    import lstypes::*;

    localparam int NPHYS   = 56;
    localparam int NUM_PMP = 5;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        csr_wr_valid = 1'b0;
    logic        csr_wr_ready;
    logic        csr_wr_sel = 1'b0;
    logic [2:0]  csr_wr_index = 3'd0;
    logic [63:0] csr_wr_data = '0;
    logic        csr_rd_sel = 1'b0;
    logic [2:0]  csr_rd_index = 3'd0;
    logic [63:0] csr_rd_data;
    logic        busy;
    ctrl_state_e dbg_state;

    pmp_csr_ctrl_if #(.NPHYS(NPHYS), .NUM_PMP(NUM_PMP)) pmp_bus ();

    pmp_csr_ctrl #(.NPHYS(NPHYS), .NUM_PMP(NUM_PMP)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .csr_wr_valid (csr_wr_valid),
        .csr_wr_ready (csr_wr_ready),
        .csr_wr_sel   (csr_wr_sel),
        .csr_wr_index (csr_wr_index),
        .csr_wr_data  (csr_wr_data),
        .csr_rd_sel   (csr_rd_sel),
        .csr_rd_index (csr_rd_index),
        .csr_rd_data  (csr_rd_data),
        .busy         (busy),
        .o_dbg_state  (dbg_state),
        .pmp          (pmp_bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        sel;
        logic [2:0]  idx;
        logic [63:0] data;
        int          ent;
        logic        v;
        logic        l;
        logic [2:0]  p;
        logic [63:0] s;
        logic [63:0] a;
        logic        rsel;
        logic [2:0]  ridx;
        logic [63:0] rexp;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic do_write(input string tag, input logic sel, input logic [2:0] idx,
                            input logic [63:0] data);
        int n;
        n = 0;
        @(negedge clk);
        csr_wr_sel   = sel;
        csr_wr_index = idx;
        csr_wr_data  = data;
        csr_wr_valid = 1'b1;
        while (!csr_wr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!csr_wr_ready) chk({tag, ".accept_timeout"}, 64'(csr_wr_ready), 64'd1);
        @(negedge clk);
        csr_wr_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk({tag, ".idle_timeout"}, 64'(busy), 64'd0);
    endtask

    task automatic check_entry(input string tag, input int e, input logic v, input logic l,
                               input logic [2:0] p, input logic [63:0] s, input logic [63:0] a);
        chk({tag, ".valid"},  64'(pmp_bus.valid[e]),  64'(v));
        chk({tag, ".locked"}, 64'(pmp_bus.locked[e]), 64'(l));
        chk({tag, ".prot"},   64'(pmp_bus.prot[e]),   64'(p));
        if (v) begin
            chk({tag, ".start"}, 64'(pmp_bus.start[e]), s);
            chk({tag, ".aend"},  64'(pmp_bus.aend[e]),  a);
        end
    endtask

    function automatic vec_t mkv(logic sel, logic [2:0] idx, logic [63:0] data, int ent,
                                 logic v, logic l, logic [2:0] p, logic [63:0] s,
                                 logic [63:0] a, logic rsel, logic [2:0] ridx,
                                 logic [63:0] rexp);
        vec_t t;
        t.sel = sel; t.idx = idx; t.data = data; t.ent = ent;
        t.v = v; t.l = l; t.p = p; t.s = s; t.a = a;
        t.rsel = rsel; t.ridx = ridx; t.rexp = rexp;
        return t;
    endfunction

    localparam logic [63:0] ALL54 = 64'h003F_FFFF_FFFF_FFFF;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        //        sel  idx   data                     ent v  l  p     start    aend     rsel ridx readback
        vq.push_back(mkv(1, 3'd0, 64'h100,                0, 0, 0, 3'd0, 64'h0,   64'h0,   1, 3'd0, 64'h100));
        vq.push_back(mkv(0, 3'd0, 64'h0F,                 0, 1, 0, 3'd7, 64'h0,   64'hFF,  0, 3'd0, 64'h0F));
        vq.push_back(mkv(1, 3'd1, 64'h203,                1, 0, 0, 3'd0, 64'h0,   64'h0,   1, 3'd1, 64'h203));
        vq.push_back(mkv(0, 3'd0, 64'h1B0F,               1, 1, 0, 3'd3, 64'h200, 64'h207, 0, 3'd0, 64'h1B0F));
        vq.push_back(mkv(1, 3'd1, 64'h100,                1, 1, 0, 3'd3, 64'h100, 64'h101, 1, 3'd1, 64'h100));
        vq.push_back(mkv(0, 3'd0, 64'h0F0F,               1, 0, 0, 3'd7, 64'h0,   64'h0,   0, 3'd0, 64'h0F0F));
        vq.push_back(mkv(0, 3'd0, 64'h170F0F,             2, 0, 0, 3'd7, 64'h0,   64'h0,   0, 3'd0, 64'h070F0F));
        vq.push_back(mkv(0, 3'd0, 64'h1A070F0F,           3, 1, 0, 3'd0, 64'h0,   64'h1,   0, 3'd0, 64'h18070F0F));
        vq.push_back(mkv(1, 3'd4, 64'hFFFF_FFFF_FFFF_FFFF, 4, 0, 0, 3'd0, 64'h0,  64'h0,   1, 3'd4, ALL54));
        vq.push_back(mkv(0, 3'd0, 64'h0F_1818_070F_0F,    4, 1, 0, 3'd0, 64'h0,   ALL54,   0, 3'd0, 64'h18_1807_0F0F));
        vq.push_back(mkv(1, 3'd6, 64'h55,                 0, 1, 0, 3'd7, 64'h0,   64'hFF,  1, 3'd6, 64'h0));
        vq.push_back(mkv(0, 3'd0, 64'h18_1807_0F8F,       0, 1, 1, 3'd7, 64'h0,   64'hFF,  0, 3'd0, 64'h18_1807_0F8F));
        vq.push_back(mkv(1, 3'd0, 64'h500,                0, 1, 1, 3'd7, 64'h0,   64'hFF,  1, 3'd0, 64'h100));
        vq.push_back(mkv(0, 3'd0, 64'h18_1807_0F00,       0, 1, 1, 3'd7, 64'h0,   64'hFF,  0, 3'd0, 64'h18_1807_0F8F));
        vq.push_back(mkv(0, 3'd0, 64'h18_8807_0F00,       3, 0, 1, 3'd0, 64'h0,   64'h0,   0, 3'd0, 64'h18_8807_0F8F));
        vq.push_back(mkv(1, 3'd2, 64'h300,                2, 0, 0, 3'd7, 64'h0,   64'h0,   1, 3'd2, 64'h0));
        vq.push_back(mkv(1, 3'd1, 64'h150,                1, 1, 0, 3'd7, 64'h100, 64'h14F, 1, 3'd1, 64'h150));

        // Reset state.
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst.ready", 64'(csr_wr_ready), 64'd1);
        chk("rst.busy",  64'(busy), 64'd0);
        chk("rst.state", 64'(dbg_state), 64'(IDLE));
        chk("rst.valid", 64'(pmp_bus.valid), 64'd0);
        csr_rd_sel = 1'b0;
        #1;
        chk("rst.cfg_rd", csr_rd_data, 64'd0);

        // Table-driven writes.
        for (int i = 0; i < vq.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            do_write(tag, vq[i].sel, vq[i].idx, vq[i].data);
            wait_idle(tag);
            check_entry(tag, vq[i].ent, vq[i].v, vq[i].l, vq[i].p, vq[i].s, vq[i].a);
            csr_rd_sel   = vq[i].rsel;
            csr_rd_index = vq[i].ridx;
            #1;
            chk({tag, ".rd"}, csr_rd_data, vq[i].rexp);
        end

        // Back-to-back: second write held for exactly NUM_PMP cycles.
        @(negedge clk);
        csr_wr_sel   = 1'b0;
        csr_wr_data  = 64'h18_8807_0F8F;
        csr_wr_valid = 1'b1;
        chk("b2b.ready_first", 64'(csr_wr_ready), 64'd1);
        @(negedge clk);
        csr_wr_sel   = 1'b1;
        csr_wr_index = 3'd1;
        csr_wr_data  = 64'h160;
        chk("b2b.busy", 64'(busy), 64'd1);
        n = 0;
        while (!csr_wr_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("b2b.held_cycles", 64'(n), 64'(NUM_PMP));
        @(negedge clk);
        csr_wr_valid = 1'b0;
        wait_idle("b2b");
        check_entry("b2b.ent1", 1, 1'b1, 1'b0, 3'd7, 64'h100, 64'h15F);
        csr_rd_sel   = 1'b1;
        csr_rd_index = 3'd1;
        #1;
        chk("b2b.rd", csr_rd_data, 64'h160);

        // Reset during the second cycle of a cfg decode.
        @(negedge clk);
        csr_wr_sel   = 1'b0;
        csr_wr_data  = 64'h18_8807_0F8F;
        csr_wr_valid = 1'b1;
        @(negedge clk);
        csr_wr_valid = 1'b0;
        @(negedge clk);
        chk("mid.busy_before", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("mid.valid",  64'(pmp_bus.valid),  64'd0);
        chk("mid.locked", 64'(pmp_bus.locked), 64'd0);
        chk("mid.busy",   64'(busy), 64'd0);
        chk("mid.start0", 64'(pmp_bus.start[0]), 64'd0);
        chk("mid.aend4",  64'(pmp_bus.aend[4]),  64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("mid.ready", 64'(csr_wr_ready), 64'd1);
        chk("mid.state", 64'(dbg_state), 64'(IDLE));
        csr_rd_sel = 1'b0;
        #1;
        chk("mid.cfg_rd", csr_rd_data, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
